// File: rtl/sst_pkg.sv
// sst_pkg: state encoding and default sizing shared by the save-state
// stream controller. Imported with import sst_pkg::*.
package sst_pkg;

  localparam int SST_REGS_DEF = 128;

  typedef enum logic [2:0] {
    IDLE,
    S_SETTLE,
    S_SEND,
    L_RECV,
    L_WRITE,
    CHK,
    DONE
  } sst_state_t;

endpackage

// File: rtl/sst_stream_ctrl_if.sv
// sst_stream_ctrl_if: mapper save-state bus plus tx/rx byte streams.
// master = controller side, slave = mapper / stream side.
interface sst_stream_ctrl_if;

  logic       sst_act;
  logic [7:0] sst_addr;
  logic [7:0] sst_dato;
  logic       sst_we_reg;
  logic [7:0] sst_di;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output sst_act, sst_addr, sst_dato, sst_we_reg,
    output tx_data, tx_valid, rx_ready,
    input  sst_di, tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  sst_act, sst_addr, sst_dato, sst_we_reg,
    input  tx_data, tx_valid, rx_ready,
    output sst_di, tx_ready, rx_data, rx_valid
  );

endinterface

// File: rtl/sst_stream_ctrl.sv
// sst_stream_ctrl: walks mapper save-state registers, streaming them out
// (save) or writing a byte stream back (restore). Ports: clk, rst_n,
// save_req, load_req, busy, done, err, bus (sst_stream_ctrl_if.master).
// Optional SST_CRC_EN appends / verifies an 8-bit mod-256 byte sum.
module sst_stream_ctrl
  import sst_pkg::*;
#(
  parameter int SST_REGS = SST_REGS_DEF,
  parameter int SETTLE   = 2,
  parameter int WE_HOLD  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic save_req,
  input  logic load_req,
  output logic busy,
  output logic done,
  output logic err,
  sst_stream_ctrl_if.master bus
);

  localparam logic [7:0] LAST  = 8'(SST_REGS - 1);
  localparam logic [3:0] SET_L = 4'(SETTLE - 1);
  localparam logic [3:0] WE_L  = 4'(WE_HOLD - 1);

  sst_state_t state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] dato_q, dato_d;
  logic [7:0] txd_q, txd_d;
  logic [3:0] cnt_q, cnt_d;
  logic       we_q, we_d;
  logic       txv_q, txv_d;
  logic       rxr_q, rxr_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       fin;
`ifdef SST_CRC_EN
  logic [7:0] sum_q, sum_d;
  logic       save_q, save_d;
  logic       err_q, err_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      dato_q  <= '0;
      txd_q   <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      txv_q   <= 1'b0;
      rxr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SST_CRC_EN
      sum_q   <= '0;
      save_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dato_q  <= dato_d;
      txd_q   <= txd_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      txv_q   <= txv_d;
      rxr_q   <= rxr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SST_CRC_EN
      sum_q   <= sum_d;
      save_q  <= save_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dato_d  = dato_q;
    txd_d   = txd_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    txv_d   = txv_q;
    rxr_d   = rxr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fin     = 1'b0;
`ifdef SST_CRC_EN
    sum_d   = sum_q;
    save_d  = save_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        addr_d = '0;
        cnt_d  = '0;
        if (save_req) begin
          state_d = S_SETTLE;
          busy_d  = 1'b1;
`ifdef SST_CRC_EN
          sum_d   = '0;
          save_d  = 1'b1;
          err_d   = 1'b0;
`endif
        end else if (load_req) begin
          state_d = L_RECV;
          busy_d  = 1'b1;
          rxr_d   = 1'b1;
`ifdef SST_CRC_EN
          sum_d   = '0;
          save_d  = 1'b0;
          err_d   = 1'b0;
`endif
        end
      end
      S_SETTLE: begin
        if (cnt_q == SET_L) begin
          cnt_d   = '0;
          txd_d   = bus.sst_di;
          txv_d   = 1'b1;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_SEND: begin
        if (bus.tx_ready) begin
          txv_d = 1'b0;
`ifdef SST_CRC_EN
          sum_d = sum_q + txd_q;
`endif
          if (addr_q == LAST) begin
            state_d = CHK;
`ifdef SST_CRC_EN
            txd_d   = sum_q + txd_q;
            txv_d   = 1'b1;
`endif
          end else begin
            addr_d  = addr_q + 8'd1;
            state_d = S_SETTLE;
          end
        end
      end
      L_RECV: begin
        if (bus.rx_valid) begin
          dato_d  = bus.rx_data;
          rxr_d   = 1'b0;
          we_d    = 1'b1;
          cnt_d   = '0;
          state_d = L_WRITE;
`ifdef SST_CRC_EN
          sum_d   = sum_q + bus.rx_data;
`endif
        end
      end
      L_WRITE: begin
        if (cnt_q == WE_L) begin
          we_d  = 1'b0;
          cnt_d = '0;
          if (addr_q == LAST) begin
            state_d = CHK;
`ifdef SST_CRC_EN
            rxr_d   = 1'b1;
`endif
          end else begin
            addr_d  = addr_q + 8'd1;
            rxr_d   = 1'b1;
            state_d = L_RECV;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      CHK: begin
`ifdef SST_CRC_EN
        if (save_q) begin
          if (bus.tx_ready) begin
            txv_d = 1'b0;
            fin   = 1'b1;
          end
        end else if (bus.rx_valid) begin
          rxr_d = 1'b0;
          err_d = (bus.rx_data != sum_q);
          fin   = 1'b1;
        end
`else
        fin = 1'b1;
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // busy falls on the same edge that raises done
    if (fin) begin
      state_d = DONE;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      addr_d  = '0;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign bus.sst_act    = busy_q;
  assign bus.sst_addr   = addr_q;
  assign bus.sst_dato   = dato_q;
  assign bus.sst_we_reg = we_q;
  assign bus.tx_data    = txd_q;
  assign bus.tx_valid   = txv_q;
  assign bus.rx_ready   = rxr_q;
`ifdef SST_CRC_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sst_stream_ctrl.sv
// tb_sst_stream_ctrl: directed save/restore/reset scenarios checked
// against queue-based expectations of the byte streams and write bursts.
module tb_sst_stream_ctrl;

  localparam int REGS = 128;
  localparam int SET  = 2;
  localparam int WEH  = 4;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic clk;
  logic rst_n;
  logic save_req;
  logic load_req;
  logic busy;
  logic done;
  logic err;

  sst_stream_ctrl_if bus ();

  sst_stream_ctrl #(
    .SST_REGS (REGS),
    .SETTLE   (SET),
    .WE_HOLD  (WEH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .save_req (save_req),
    .load_req (load_req),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .bus      (bus.master)
  );

  assign bus.sst_di = bus.sst_addr ^ 8'h5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_tx[$];
  wr_t        exp_wr[$];
  logic [7:0] tx_log[$];
  int         n_done = 0;
  int         n_burst = 0;
  int         n_rxr = 0;
  bit         stress = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready = stress ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: stream order, stall stability, spacing, bursts.
  initial begin
    bit         stall;
    logic [7:0] stall_d;
    int         we_run;
    int         last_hs;
    int         cyc;
    wr_t        cur;
    logic [7:0] e;
    stall   = 1'b0;
    stall_d = '0;
    we_run  = 0;
    last_hs = -1;
    cyc     = 0;
    cur     = '{8'h00, 8'h00};
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall   = 1'b0;
        we_run  = 0;
        last_hs = -1;
      end else begin
        cyc++;
        chk("addr_range", 32'(int'(bus.sst_addr) >= REGS), 0);
        if (!busy) chk("idle_addr", 32'(bus.sst_addr), 0);
        chk("act_busy", 32'(bus.sst_act), 32'(busy));
        if (stall) begin
          chk("stall_valid", 32'(bus.tx_valid), 1);
          chk("stall_data", 32'(bus.tx_data), 32'(stall_d));
        end
        if (bus.tx_valid && bus.tx_ready) begin
          tx_log.push_back(bus.tx_data);
          if (exp_tx.size() == 0) begin
            chk("tx_extra", 1, 0);
          end else begin
            e = exp_tx.pop_front();
            chk("tx_byte", 32'(bus.tx_data), 32'(e));
          end
          if (last_hs >= 0)
            chk("tx_spacing", 32'(cyc - last_hs >= SET + 1), 1);
          last_hs = cyc;
        end
        stall   = bus.tx_valid && !bus.tx_ready;
        stall_d = bus.tx_data;
        if (bus.sst_we_reg) begin
          if (we_run == 0) begin
            if (exp_wr.size() == 0) begin
              chk("wr_extra", 1, 0);
              cur = '{bus.sst_addr, bus.sst_dato};
            end else begin
              cur = exp_wr.pop_front();
            end
          end
          chk("wr_addr", 32'(bus.sst_addr), 32'(cur.a));
          chk("wr_data", 32'(bus.sst_dato), 32'(cur.d));
          we_run++;
        end else if (we_run != 0) begin
          chk("we_len", 32'(we_run), WEH);
          n_burst++;
          we_run = 0;
        end
        if (done) n_done++;
        if (bus.rx_ready) n_rxr++;
      end
    end
  end

  function automatic logic [7:0] save_sum();
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < REGS; i++) s = s + (8'(i) ^ 8'h5A);
    return s;
  endfunction

  task automatic push_save();
    for (int i = 0; i < REGS; i++) exp_tx.push_back(8'(i) ^ 8'h5A);
`ifdef SST_CRC_EN
    exp_tx.push_back(save_sum());
`endif
  endtask

  task automatic pulse(input bit s, input bit l);
    @(posedge clk);
    #1;
    save_req = s;
    load_req = l;
    @(posedge clk);
    #1;
    save_req = 1'b0;
    load_req = 1'b0;
  endtask

  task automatic wait_done(input string name, output logic e);
    bit seen;
    seen = 1'b0;
    e = 1'b0;
    for (int i = 0; i < 6000 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        e = err;
      end
    end
    if (!seen) chk(name, 0, 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit hs;
    hs = 1'b0;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int i = 0; i < 100 && !hs; i++) begin
      @(negedge clk);
      if (bus.rx_ready) hs = 1'b1;
      else @(posedge clk);
    end
    if (!hs) chk("rx_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic run_restore(input logic [7:0] crc);
    for (int i = 0; i < REGS; i++) begin
      exp_wr.push_back('{8'(i), 8'(i)});
      send_byte(8'(i));
    end
`ifdef SST_CRC_EN
    send_byte(crc);
`else
    if (crc != 8'h00) chk("crc_arg", 32'(crc), 32'(crc));
`endif
  endtask

  int         b0;
  int         d0;
  int         w0;
  int         r0;
  logic       e_done;

  initial begin
    rst_n        = 1'b0;
    save_req     = 1'b0;
    load_req     = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    #23;
    chk("reset_outs",
        32'({busy, done, err, bus.sst_act, bus.sst_addr, bus.sst_dato,
             bus.sst_we_reg, bus.tx_data, bus.tx_valid, bus.rx_ready}), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // plain save
    push_save();
    b0 = tx_log.size();
    d0 = n_done;
    pulse(1'b1, 1'b0);
    chk("busy_on", 32'({busy, bus.sst_act}), 32'h3);
    wait_done("save_done", e_done);
    @(negedge clk);
    chk("save_count", 32'(tx_log.size() - b0), 32'(exp_tx.size() == 0 ? tx_log.size() - b0 : 0));
    chk("save_first", 32'(tx_log[b0]), 32'h5A);
    chk("save_last", 32'(tx_log[b0 + 127]), 32'h25);
    chk("save_done_n", 32'(n_done - d0), 1);
    chk("save_err", 32'(e_done), 0);
    chk("save_busy_off", 32'(busy), 0);
`ifdef SST_CRC_EN
    chk("save_len", 32'(tx_log.size() - b0), 129);
    chk("save_crc", 32'(tx_log[b0 + 128]), 32'hC0);
`else
    chk("save_len", 32'(tx_log.size() - b0), 128);
`endif

    // save with random tx_ready stalls
    stress = 1'b1;
    push_save();
    b0 = tx_log.size();
    pulse(1'b1, 1'b0);
    wait_done("stress_done", e_done);
    stress = 1'b0;
    @(negedge clk);
    chk("stress_left", 32'(exp_tx.size()), 0);
    chk("stress_first", 32'(tx_log[b0]), 32'h5A);
    chk("stress_last", 32'(tx_log[b0 + 127]), 32'h25);

    // restore 0..127
    w0 = n_burst;
    d0 = n_done;
    pulse(1'b0, 1'b1);
    run_restore(8'hC0);
    wait_done("load_done", e_done);
    @(negedge clk);
    chk("load_bursts", 32'(n_burst - w0), 128);
    chk("load_wr_left", 32'(exp_wr.size()), 0);
    chk("load_done_n", 32'(n_done - d0), 1);
    chk("load_err", 32'(e_done), 0);

    // simultaneous request: save wins; mid-save load ignored
    push_save();
    b0 = tx_log.size();
    w0 = n_burst;
    r0 = n_rxr;
    pulse(1'b1, 1'b1);
    for (int i = 0; i < 2000 && bus.sst_addr != 8'd10; i++) @(negedge clk);
    chk("mid_addr", 32'(bus.sst_addr), 10);
    pulse(1'b0, 1'b1);
    wait_done("both_done", e_done);
    @(negedge clk);
    chk("both_tx_left", 32'(exp_tx.size()), 0);
    chk("both_bursts", 32'(n_burst - w0), 0);
    chk("both_rxr", 32'(n_rxr - r0), 0);

    // reset mid-save at address 40
    push_save();
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 2000 && bus.sst_addr != 8'd40; i++) @(negedge clk);
    chk("rst_addr40", 32'(bus.sst_addr), 40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_outs",
        32'({busy, done, err, bus.sst_act, bus.sst_addr, bus.sst_dato,
             bus.sst_we_reg, bus.tx_data, bus.tx_valid, bus.rx_ready}), 0);
    exp_tx.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_resume", 32'({busy, bus.tx_valid}), 0);
    push_save();
    b0 = tx_log.size();
    pulse(1'b1, 1'b0);
    wait_done("restart_done", e_done);
    @(negedge clk);
    chk("restart_first", 32'(tx_log[b0]), 32'h5A);
    chk("restart_left", 32'(exp_tx.size()), 0);

`ifdef SST_CRC_EN
    // restore with a corrupted checksum byte
    pulse(1'b0, 1'b1);
    run_restore(8'hC1);
    wait_done("crc_done", e_done);
    chk("crc_err", 32'(e_done), 1);
    @(negedge clk);
    chk("crc_err_sticky", 32'(err), 1);
    chk("crc_sum_model", 32'(save_sum()), 32'hC0);
`endif

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
